// File: rtl/tri_pkg.sv
// Shared definitions for the TRI custom instruction: opcode value, field positions, predecode helper.
// Imported by the fetch stage and by decode.
package tri_pkg;

  localparam logic [7:0] OPC_TRI = 8'hAA;

  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 24;
  localparam int unsigned RD_MSB  = 23;
  localparam int unsigned RD_LSB  = 19;
  localparam int unsigned RS1_MSB = 18;
  localparam int unsigned RS1_LSB = 14;
  localparam int unsigned RS2_MSB = 13;
  localparam int unsigned RS2_LSB = 9;
  localparam int unsigned RS3_MSB = 8;
  localparam int unsigned RS3_LSB = 4;

  // Field view of a TRI word; the low nibble is not used by the TRI format.
  typedef struct packed {
    logic [7:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rs3;
    logic [3:0] rsvd;
  } tri_instr_t;

  function automatic logic is_tri(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_TRI;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Registered prefetch FIFO with synchronous flush; head is read straight from storage (no bypass).
// Depth must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int unsigned Width = 36,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] push_data,
  input  logic             pop,
  output logic [Width-1:0] head,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      // Cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= push_data;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

  assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/tri_fetch_unit.sv
// Instruction fetch stage: credit-limited issue to a synchronous IMEM, prefetch FIFO of {word, pc},
// valid/ready delivery to decode with TRI predecode, redirect (flush + refetch) and halt.
module tri_fetch_unit
  import tri_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_is_tri,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              idle
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned EntryW = 32 + ADDR_W;

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [ADDR_W-1:0] issued_pc_q;
  logic              in_flight_q;

  logic              issue, push, pop, squash;
  logic [CntW:0]     credits_used;
  logic              has_credit;

  logic [EntryW-1:0] fifo_head;
  logic [CntW-1:0]   fifo_count;
  logic              fifo_full, fifo_empty;

  // Occupancy plus the outstanding response must stay below depth, so a push always finds room.
  always_comb begin
    credits_used = {1'b0, fifo_count} + {{CntW{1'b0}}, in_flight_q};
    has_credit   = credits_used < (CntW + 1)'(FIFO_DEPTH);
    issue        = !rst && !halt && !redirect_valid && has_credit;
  end

  always_comb begin
    pc_inc = (pc_q == ADDR_W'(IMEM_DEPTH - 1)) ? '0 : pc_q + 1'b1;
    pc_d   = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (issue) begin
      pc_d = pc_inc;
    end
  end

  // A response landing in a redirect cycle belongs to the old stream and is dropped.
  always_comb begin
    squash = in_flight_q && redirect_valid;
    push   = in_flight_q && !squash;
    pop    = out_valid && out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      issued_pc_q <= '0;
      in_flight_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      in_flight_q <= issue;
      if (issue) begin
        issued_pc_q <= pc_q;
      end
    end
  end

  fetch_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({imem_rdata, issued_pc_q}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    imem_en    = issue;
    imem_addr  = pc_q;
    out_valid  = !fifo_empty && !redirect_valid;
    out_instr  = fifo_head[EntryW-1:ADDR_W];
    out_pc     = fifo_head[ADDR_W-1:0];
    out_is_tri = is_tri(out_instr);
    idle       = !in_flight_q && fifo_empty;
  end

  assert property (@(posedge clk) disable iff (rst) !(push && fifo_full));

endmodule

// File: tb/tb_tri_fetch_unit.sv
// Directed bench for tri_fetch_unit: streaming, backpressure, redirect, wrap, halt and async reset.
// Inputs change and outputs are sampled just after the falling edge.
module tb_tri_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_en;
  logic [3:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [3:0]  out_pc;
  logic        out_is_tri;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        halt;
  logic        idle;

  logic [31:0] imem [16];
  int          n_vec;
  int          n_bad;

  tri_fetch_unit #(
    .IMEM_DEPTH (16),
    .ADDR_W     (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_is_tri     (out_is_tri),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .idle           (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data one cycle after the request.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem[imem_addr];
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic restart();
    rst = 1'b1;
    redirect_valid = 1'b0;
    halt = 1'b0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string tag, input int limit, output int waited);
    waited = 0;
    while (!out_valid && waited < limit) begin
      tick();
      waited++;
    end
    n_vec++;
    if (!out_valid) begin
      $display("FAIL %s_timeout out_valid got 0 want 1 within %0d cycles", tag, limit);
      n_bad++;
    end
  endtask

  task automatic test_reset();
    tick();
    n_vec++; if (imem_en !== 1'b0) begin $display("FAIL rst_imem_en got %b want 0", imem_en); n_bad++; end
    n_vec++; if (imem_addr !== 4'd0) begin $display("FAIL rst_imem_addr got %0d want 0", imem_addr); n_bad++; end
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL rst_out_valid got %b want 0", out_valid); n_bad++; end
    n_vec++; if (out_instr !== 32'h0) begin $display("FAIL rst_out_instr got %h want 0", out_instr); n_bad++; end
    n_vec++; if (out_pc !== 4'd0) begin $display("FAIL rst_out_pc got %0d want 0", out_pc); n_bad++; end
    n_vec++; if (out_is_tri !== 1'b0) begin $display("FAIL rst_out_is_tri got %b want 0", out_is_tri); n_bad++; end
    n_vec++; if (idle !== 1'b1) begin $display("FAIL rst_idle got %b want 1", idle); n_bad++; end
  endtask

  task automatic test_streaming();
    logic [3:0] exp_tri;
    int w;
    exp_tri = 4'b0101;
    out_ready = 1'b1;
    restart();
    n_vec++; if (imem_en !== 1'b1) begin $display("FAIL stream_first_en got %b want 1", imem_en); n_bad++; end
    n_vec++; if (imem_addr !== 4'd0) begin $display("FAIL stream_first_addr got %0d want 0", imem_addr); n_bad++; end
    wait_valid("stream", 4, w);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (out_valid !== 1'b1) begin $display("FAIL stream_valid[%0d] got %b want 1", i, out_valid); n_bad++; end
      n_vec++; if (out_pc !== 4'(i)) begin $display("FAIL stream_pc[%0d] got %0d want %0d", i, out_pc, i); n_bad++; end
      n_vec++; if (out_instr !== imem[i]) begin $display("FAIL stream_instr[%0d] got %h want %h", i, out_instr, imem[i]); n_bad++; end
      n_vec++; if (out_is_tri !== exp_tri[i]) begin $display("FAIL stream_tri[%0d] got %b want %b", i, out_is_tri, exp_tri[i]); n_bad++; end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    restart();
    repeat (10) tick();
    n_vec++; if (imem_en !== 1'b0) begin $display("FAIL bp_imem_en got %b want 0", imem_en); n_bad++; end
    n_vec++; if (out_valid !== 1'b1) begin $display("FAIL bp_valid got %b want 1", out_valid); n_bad++; end
    n_vec++; if (out_pc !== 4'd0) begin $display("FAIL bp_head_pc got %0d want 0", out_pc); n_bad++; end
    n_vec++; if (idle !== 1'b0) begin $display("FAIL bp_idle got %b want 0", idle); n_bad++; end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (out_valid !== 1'b1) begin $display("FAIL bp_drain_valid[%0d] got %b want 1", i, out_valid); n_bad++; end
      n_vec++; if (out_pc !== 4'(i)) begin $display("FAIL bp_drain_pc[%0d] got %0d want %0d", i, out_pc, i); n_bad++; end
      tick();
    end
  endtask

  // Three words buffered plus one response in flight, then redirect to 9.
  task automatic test_redirect_full();
    int w;
    out_ready = 1'b0;
    restart();
    repeat (4) tick();
    n_vec++; if (imem_en !== 1'b0) begin $display("FAIL redir_pre_en got %b want 0", imem_en); n_bad++; end
    n_vec++; if (idle !== 1'b0) begin $display("FAIL redir_pre_idle got %b want 0", idle); n_bad++; end
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 4'd9;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin $display("FAIL redir_cycle_valid got %b want 0", out_valid); n_bad++; end
    n_vec++; if (imem_en !== 1'b0) begin $display("FAIL redir_cycle_en got %b want 0", imem_en); n_bad++; end
    tick();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (imem_en !== 1'b1 || imem_addr !== 4'd9) begin
      $display("FAIL redir_refetch got en=%b addr=%0d want en=1 addr=9", imem_en, imem_addr); n_bad++;
    end
    wait_valid("redir", 3, w);
    n_vec++; if (out_pc !== 4'd9) begin $display("FAIL redir_first_pc got %0d want 9", out_pc); n_bad++; end
    n_vec++; if (out_instr !== imem[9]) begin $display("FAIL redir_first_instr got %h want %h", out_instr, imem[9]); n_bad++; end
    tick();
    n_vec++; if (out_pc !== 4'd10) begin $display("FAIL redir_second_pc got %0d want 10", out_pc); n_bad++; end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_pc [4];
    logic [3:0] exp_tri;
    int w;
    exp_pc[0] = 4'd14; exp_pc[1] = 4'd15; exp_pc[2] = 4'd0; exp_pc[3] = 4'd1;
    exp_tri = 4'b0101;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 4'd14;
    tick();
    redirect_valid = 1'b0;
    #1;
    wait_valid("wrap", 4, w);
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (out_valid !== 1'b1 || out_pc !== exp_pc[i]) begin
        $display("FAIL wrap_pc[%0d] got v=%b pc=%0d want v=1 pc=%0d", i, out_valid, out_pc, exp_pc[i]); n_bad++;
      end
      n_vec++; if (out_is_tri !== exp_tri[i]) begin $display("FAIL wrap_tri[%0d] got %b want %b", i, out_is_tri, exp_tri[i]); n_bad++; end
      tick();
    end
  endtask

  task automatic test_halt();
    int w;
    out_ready = 1'b1;
    restart();
    tick();
    halt = 1'b1;
    #1;
    n_vec++; if (imem_en !== 1'b0) begin $display("FAIL halt_en got %b want 0", imem_en); n_bad++; end
    n_vec++; if (idle !== 1'b0) begin $display("FAIL halt_inflight_idle got %b want 0", idle); n_bad++; end
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 4'd0) begin
      $display("FAIL halt_landed got v=%b pc=%0d want v=1 pc=0", out_valid, out_pc); n_bad++;
    end
    tick();
    n_vec++; if (idle !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL halt_drained got idle=%b v=%b want idle=1 v=0", idle, out_valid); n_bad++;
    end
    repeat (3) tick();
    n_vec++; if (imem_en !== 1'b0 || idle !== 1'b1) begin
      $display("FAIL halt_hold got en=%b idle=%b want en=0 idle=1", imem_en, idle); n_bad++;
    end
    halt = 1'b0;
    #1;
    n_vec++; if (imem_en !== 1'b1 || imem_addr !== 4'd1) begin
      $display("FAIL halt_resume got en=%b addr=%0d want en=1 addr=1", imem_en, imem_addr); n_bad++;
    end
    wait_valid("halt_resume", 4, w);
    n_vec++; if (out_pc !== 4'd1) begin $display("FAIL halt_resume_pc got %0d want 1", out_pc); n_bad++; end
  endtask

  task automatic test_reset_mid();
    int w;
    out_ready = 1'b1;
    restart();
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (imem_en !== 1'b0 || imem_addr !== 4'd0) begin
      $display("FAIL mid_rst_imem got en=%b addr=%0d want en=0 addr=0", imem_en, imem_addr); n_bad++;
    end
    n_vec++; if (out_valid !== 1'b0 || out_pc !== 4'd0 || out_instr !== 32'h0) begin
      $display("FAIL mid_rst_out got v=%b pc=%0d instr=%h want v=0 pc=0 instr=0", out_valid, out_pc, out_instr); n_bad++;
    end
    n_vec++; if (idle !== 1'b1) begin $display("FAIL mid_rst_idle got %b want 1", idle); n_bad++; end
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (imem_en !== 1'b1 || imem_addr !== 4'd0) begin
      $display("FAIL mid_restart got en=%b addr=%0d want en=1 addr=0", imem_en, imem_addr); n_bad++;
    end
    wait_valid("mid_restart", 4, w);
    n_vec++; if (out_pc !== 4'd0 || out_instr !== imem[0]) begin
      $display("FAIL mid_restart_head got pc=%0d instr=%h want pc=0 instr=%h", out_pc, out_instr, imem[0]); n_bad++;
    end
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 4'd0;
    halt = 1'b0;
    imem_rdata = 32'h0;
    n_vec = 0;
    n_bad = 0;
    for (int i = 0; i < 16; i++) imem[i] = 32'h0000_0100 + i;
    imem[0]  = 32'hAA00_0000;
    imem[1]  = 32'h0000_0001;
    imem[2]  = 32'hAA12_3450;
    imem[3]  = 32'h0000_0000;
    imem[14] = 32'hAA00_00E0;

    test_reset();
    test_streaming();
    test_backpressure();
    test_redirect_full();
    test_wrap();
    test_halt();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog simulation did not complete within 50000 time units");
    $fatal(1);
  end

endmodule

// File: doc/tri_fetch_unit.md
# tri_fetch_unit

Instruction fetch stage that sits directly upstream of the mini CPU's decode/execute logic. It reads 32-bit words from a synchronous instruction memory and buffers them, with their PCs, in a small prefetch FIFO. It presents them to decode over a valid/ready handshake and pre-flags custom TRI instructions (opcode 0xAA in bits [31:24]). It supports redirect (flush and refetch) and halt.

## Interface
- IMEM_DEPTH, 16, number of instruction words; PC wraps modulo this value (power of two).
- ADDR_W, 4, word-address width, equal to log2(IMEM_DEPTH).
- FIFO_DEPTH, 4, prefetch entries (power of two, ≥2).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_en  out  1  read request this cycle.
- imem_addr  out  ADDR_W  word address of the request.
- imem_rdata  in  32  read data; valid exactly one cycle after a request with imem_en=1.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  decode accepts the head.
- out_instr  out  32  head instruction word.
- out_pc  out  ADDR_W  head word address.
- out_is_tri  out  1  head opcode == 8'hAA.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  restart address.
- halt  in  1  level; stop issuing new requests.
- idle  out  1  no request in flight and FIFO empty.

## Operation
- Reset values: fetch PC 0, FIFO empty, in-flight flag 0, imem_en 0, imem_addr 0, out_valid 0, out_instr 0, out_pc 0, out_is_tri 0, idle 1.
- Issue rule: imem_en=1 when !halt, !redirect_valid, and (occupancy + in_flight) < FIFO_DEPTH. imem_addr = fetch PC. On issue, fetch PC increments with wrap from IMEM_DEPTH-1 to 0, and in_flight is set for the next cycle.
- Response: in the cycle after an issue, {imem_rdata, issued PC} is pushed into the FIFO unless that response has been squashed. The credit rule guarantees a push is never dropped for lack of space.
- Pop: occurs when out_valid && out_ready. A push and a pop in the same cycle leave occupancy unchanged. Pop from empty cannot happen because out_valid is 0.
- out_is_tri is derived from the head word's [31:24] and is meaningful only while out_valid=1.
- Redirect (takes priority over everything):
  - In the cycle redirect_valid=1, out_valid is forced 0 combinationally, so no transfer occurs, and imem_en=0.
  - At the clock edge: the FIFO is emptied, any in-flight response is marked squashed and is not pushed, and fetch PC is set to redirect_pc.
- Halt: stops new issues only. A request already in flight still lands in the FIFO, and the FIFO continues to drain. Deasserting halt resumes at the saved fetch PC.
- idle = !in_flight && FIFO empty.
- Asserting rst mid-operation immediately returns all state to the reset values. A response arriving after reset is ignored.

## Timing
- Reset released before edge E0: imem_en=1 with addr 0 during cycle 0. The word is pushed at edge E1, and out_valid=1 during cycle 1 with out_pc=0.
- Issue-to-out_valid latency is 1 cycle (registered FIFO, no bypass). Sustained throughput is 1 instruction per cycle when out_ready is held high.
- Redirect in cycle N: first fetch of redirect_pc in cycle N+1; that instruction is visible at the FIFO head in cycle N+2.
- With out_ready held low, the fetch unit stops issuing once occupancy + in_flight = FIFO_DEPTH, so exactly FIFO_DEPTH words are buffered.

## Structure
- Package tri_pkg holds OPC_TRI = 8'hAA and the field bit positions: opcode [31:24], rd [23:19], rs1 [18:14], rs2 [13:9], rs3 [8:4]. Decode shares this package.
- Sub-module fetch_fifo: synchronous FIFO with a synchronous flush input, parameterised by width (32 + ADDR_W) and FIFO_DEPTH, providing count/full/empty outputs.
- Top level contains the PC register, in-flight/squash flags, credit logic and predecode.

## Test plan
- Streaming:
  - Stimulus: imem[0..3] = AA000000, 00000001, AA123450, 00000000; out_ready held at 1.
  - Required response: out_pc 0,1,2,3 on consecutive cycles; out_is_tri 1,0,1,0.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles.
  - Required response: exactly 4 words buffered (PCs 0–3) and imem_en=0 thereafter. Releasing out_ready delivers PCs 0–3 and then 4 with none lost or duplicated.
- Wrap:
  - Stimulus: redirect to 14, out_ready=1.
  - Required response: out_pc sequence 14, 15, 0, 1.
- Redirect with full FIFO and in-flight request:
  - Stimulus: redirect_pc=9.
  - Required response: no transfer occurs in the redirect cycle, the old words never appear, and the next out_pc is 9, two cycles after the redirect.
- Halt, then reset mid-stream:
  - Stimulus: assert halt while a request is in flight; later assert rst asynchronously mid-stream.
  - Required response for halt: the in-flight word is still delivered, then idle=1 once the FIFO drains, and fetch resumes at the correct PC after halt is deasserted.
  - Required response for rst: outputs go to their reset values immediately, and fetch restarts at PC 0.
